// File: rtl/fpu_pkg.sv
// Shared FPU format constants and types.
// Format: sign[31], exponent[30:25] biased by 31, mantissa[24:0] with hidden leading 1.
package fpu_pkg;

  localparam int unsigned EXP_W  = 6;
  localparam int unsigned MANT_W = 25;
  localparam int unsigned BIAS   = 31;

  // status_out bit positions
  localparam int unsigned ST_ZERO    = 0;
  localparam int unsigned ST_INEXACT = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_NEG     = 3;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PACK
  } f2i_state_t;

endpackage

// File: rtl/fpu_f2i_if.sv
// Start/done handshake and data bus of the float-to-integer converter.
//   start      request, sampled only while busy=0
//   op_in      FPU-format operand
//   busy       converter not idle
//   done       one-cycle completion pulse
//   data_out   signed integer result
//   status_out {neg, overflow, inexact, zero}
interface fpu_f2i_if;
  logic        start;
  logic [31:0] op_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  modport master (
    output start, op_in,
    input  busy, done, data_out, status_out
  );

  modport slave (
    input  start, op_in,
    output busy, done, data_out, status_out
  );
endinterface

// File: rtl/fpu_unpack.sv
// Combinational field decoder for an FPU-format word.
//   word     FPU-format operand
//   sign     sign bit
//   exp_unb  unbiased exponent, signed (-31..32)
//   sig      significand with hidden 1 restored (MANT_W fraction bits)
//   zero     exact zero (magnitude bits all clear)
module fpu_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]              word,
  output logic                     sign,
  output logic signed [EXP_W:0]    exp_unb,
  output logic [MANT_W:0]          sig,
  output logic                     zero
);

  localparam logic [EXP_W:0] BiasV = (EXP_W + 1)'(BIAS);

  logic [EXP_W:0] e_ext;

  assign e_ext   = {1'b0, word[MANT_W +: EXP_W]};
  assign sign    = word[31];
  assign exp_unb = $signed(e_ext - BiasV);
  assign sig     = {1'b1, word[MANT_W-1:0]};
  assign zero    = (word[30:0] == '0);

endmodule

// File: rtl/fpu_f2i.sv
// Sequential float-to-integer converter (truncate toward zero, saturate on overflow).
// A bit-serial shifter aligns the significand one position per cycle.
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    slave side of fpu_f2i_if (start/op_in in; busy/done/data_out/status_out out)
module fpu_f2i
  import fpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  fpu_f2i_if.slave   bus
);

  localparam logic signed [EXP_W:0] EMant = (EXP_W + 1)'(MANT_W);
  localparam logic signed [EXP_W:0] ETop  = (EXP_W + 1)'(31);

  logic                  u_sign;
  logic signed [EXP_W:0] u_exp;
  logic [MANT_W:0]       u_sig;
  logic                  u_zero;

  fpu_unpack u_unpack (
    .word    (bus.op_in),
    .sign    (u_sign),
    .exp_unb (u_exp),
    .sig     (u_sig),
    .zero    (u_zero)
  );

  f2i_state_t  state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic        sticky_q, sticky_d;
  logic        ovf_q, ovf_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  status_q, status_d;
  logic        done_q, done_d;

  logic signed [EXP_W:0] rdist, ldist;
  logic [31:0]           pack_data;
  logic [3:0]            pack_status;

  assign rdist = EMant - u_exp;
  assign ldist = u_exp - EMant;

  // Negating zero yields zero, so no separate magnitude!=0 guard is needed.
  always_comb begin
    pack_data = '0;
    if (ovf_q) begin
      pack_data = sign_q ? INT_MIN : INT_MAX;
    end else begin
      pack_data = sign_q ? -mag_q : mag_q;
    end
    pack_status             = '0;
    pack_status[ST_ZERO]    = (pack_data == '0);
    pack_status[ST_INEXACT] = sticky_q & ~ovf_q;
    pack_status[ST_OVF]     = ovf_q;
    pack_status[ST_NEG]     = pack_data[31];
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    data_d   = data_q;
    status_d = status_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d   = u_sign;
          sticky_d = 1'b0;
          ovf_d    = 1'b0;
          left_d   = 1'b0;
          cnt_d    = '0;
          mag_d    = '0;
          state_d  = PACK;
          if (u_zero) begin
            // result 0, status zero only
          end else if (u_exp[EXP_W]) begin
            // |x| < 1: truncates to 0 but bits were lost
            sticky_d = 1'b1;
          end else if (u_exp > ETop ||
                       (u_exp == ETop && !(u_sign && u_sig[MANT_W-1:0] == '0))) begin
            ovf_d = 1'b1;
          end else if (u_exp == ETop) begin
            // exactly -2^31 is representable
            mag_d = INT_MIN;
          end else begin
            mag_d   = 32'(u_sig);
            state_d = SHIFT;
            if (u_exp <= EMant) begin
              cnt_d = rdist[4:0];
            end else begin
              cnt_d  = ldist[4:0];
              left_d = 1'b1;
            end
          end
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          if (left_q) begin
            mag_d = mag_q << 1;
          end else begin
            mag_d    = mag_q >> 1;
            sticky_d = sticky_q | mag_q[0];
          end
          cnt_d = cnt_q - 5'd1;
        end else begin
          state_d = PACK;
        end
      end
      PACK: begin
        data_d   = pack_data;
        status_d = pack_status;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.data_out   = data_q;
  assign bus.status_out = status_q;

endmodule
